mrd_rdx2345_wb: RTL and testbench

//  Write-back stage directly downstream of the radix-2/3/4/5 DFT+twiddle stage. Takes one 5-lane beat/cycle
//  (per-lane bank index, bank address, complex sample) and routes each lane through a 5x5 crossbar onto the
//  5 data-memory bank write ports. Counts beats per stage, pulses stage_done, flags bank conflicts/protocol errors.

---
 rtl/mrd_pkg.sv | 9 +
 rtl/mrd_wb_narrow.sv | 18 +
 rtl/mrd_rdx2345_wb.sv | 98 +++++++++
 tb/tb_mrd_rdx2345_wb.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mrd_pkg.sv
// mrd_pkg: shared lane/bank counts, write-back FSM states and crossbar array types
package mrd_pkg;
  localparam int N_LANE = 5;
  localparam int N_BANK = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE} wb_state_t;
  typedef logic [0:N_LANE-1][2:0] lane_idx_t;
  typedef logic [0:N_BANK-1][2:0] bank_sel_t;
  typedef logic [0:N_BANK-1] bank_en_t;
endpackage

// File: rtl/mrd_wb_narrow.sv
// mrd_wb_narrow: reduces one signed component to wOut bits; saturates when MRD_RDX2345_WB_SAT_EN is defined, else wraps
module mrd_wb_narrow #(
  parameter int wIn = 30,
  parameter int wOut = 18
) (
  input  logic signed [wIn-1:0] din,
  output logic [wOut-1:0] dout
);
`ifdef MRD_RDX2345_WB_SAT_EN
  localparam logic signed [wIn-1:0] MAX = wIn'((1 << (wOut - 1)) - 1);
  localparam logic signed [wIn-1:0] MIN = -MAX - 1;
  assign dout = din > MAX ? {1'b0, {(wOut-1){1'b1}}} : din < MIN ? {1'b1, {(wOut-1){1'b0}}} : din[wOut-1:0];
`else
  logic unused_hi;
  assign unused_hi = ^din[wIn-1:wOut];
  assign dout = din[wOut-1:0];
`endif
endmodule

// File: rtl/mrd_rdx2345_wb.sv
// mrd_rdx2345_wb: routes 5-lane beats through a 5x5 crossbar to bank write ports, counts stage beats, flags errors (saturation via MRD_RDX2345_WB_SAT_EN)
module mrd_rdx2345_wb
  import mrd_pkg::*;
#(
  parameter int wDataIn = 30,
  parameter int wMemData = 18,
  parameter int wAddr = 8,
  parameter int wLen = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic stage_start,
  input  logic [wLen-1:0] stage_len,
  input  logic in_valid,
  input  logic [0:4][2:0] in_bank_index,
  input  logic [0:4][wAddr-1:0] in_bank_addr,
  input  logic [0:4][wDataIn-1:0] in_real,
  input  logic [0:4][wDataIn-1:0] in_imag,
  output logic [0:4] wr_en,
  output logic [0:4][wAddr-1:0] wr_addr,
  output logic [0:4][2*wMemData-1:0] wr_data,
  output logic stage_done,
  output logic busy,
  output logic err_conflict,
  output logic err_proto
);
  wb_state_t state, state_nx;
  logic [wLen-1:0] cnt, len, cnt_inc;
  logic accept, start_ok, conflict, bad_idx;
  logic [0:N_LANE-1][wMemData-1:0] nr, ni;
  bank_en_t hit;
  bank_sel_t sel;
  assign accept = in_valid && state == RUN && !stage_start;
  assign start_ok = stage_start && stage_len != '0;
  assign cnt_inc = cnt + 1'b1;
  assign stage_done = state == DONE;
  assign busy = state == RUN;
  for (genvar l = 0; l < N_LANE; l++) begin : g_lane
    mrd_wb_narrow #(.wIn(wDataIn), .wOut(wMemData)) u_re (.din(in_real[l]), .dout(nr[l]));
    mrd_wb_narrow #(.wIn(wDataIn), .wOut(wMemData)) u_im (.din(in_imag[l]), .dout(ni[l]));
  end
  // next state: a start always restarts; the final accepted beat moves to DONE
  always_comb begin
    state_nx = state;
    if (stage_start) state_nx = start_ok ? RUN : IDLE;
    else if (state == DONE) state_nx = IDLE;
    else if (accept && cnt_inc == len) state_nx = DONE;
  end
  // crossbar arbitration: lowest lane claiming a bank wins, later claimants and bad indices are flagged
  always_comb begin
    hit = '0;
    sel = '0;
    conflict = 1'b0;
    bad_idx = 1'b0;
    for (int l = 0; l < N_LANE; l++)
      if (in_bank_index[l] >= 3'(N_BANK)) bad_idx = 1'b1;
      else if (hit[in_bank_index[l]]) conflict = 1'b1;
      else begin
        hit[in_bank_index[l]] = 1'b1;
        sel[in_bank_index[l]] = 3'(l);
      end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // beat counter, latched length and sticky error flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      len <= '0;
      err_conflict <= 1'b0;
      err_proto <= 1'b0;
    end else if (stage_start) begin
      cnt <= '0;
      len <= stage_len;
      err_conflict <= 1'b0;
      err_proto <= stage_len == '0;
    end else begin
      if (accept) cnt <= cnt_inc;
      if (accept && conflict) err_conflict <= 1'b1;
      if ((accept && bad_idx) || (in_valid && state != RUN)) err_proto <= 1'b1;
    end
  // bank write ports: unwritten banks keep their last address and data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_en <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else
      for (int b = 0; b < N_BANK; b++) begin
        wr_en[b] <= accept && hit[b];
        if (accept && hit[b]) begin
          wr_addr[b] <= in_bank_addr[sel[b]];
          wr_data[b] <= {nr[sel[b]], ni[sel[b]]};
        end
      end
endmodule

// File: tb/tb_mrd_rdx2345_wb.sv
// tb_mrd_rdx2345_wb: directed plus randomized beats checked against a behavioural write-back model
module tb_mrd_rdx2345_wb;
  logic clk = 0, rst_n = 0, stage_start = 0, in_valid = 0;
  logic [10:0] stage_len = '0;
  logic [0:4][2:0] in_bank_index = '0;
  logic [0:4][7:0] in_bank_addr = '0;
  logic [0:4][29:0] in_real = '0, in_imag = '0;
  logic [0:4] wr_en;
  logic [0:4][7:0] wr_addr;
  logic [0:4][35:0] wr_data;
  logic stage_done, busy, err_conflict, err_proto;
  int errs = 0, checks = 0;
  int m_state, m_cnt, m_len;
  logic [0:4] m_en;
  logic [7:0] m_addr [5];
  logic [35:0] m_data [5];
  logic m_conf, m_proto;

  mrd_rdx2345_wb dut (
    .clk(clk), .rst_n(rst_n), .stage_start(stage_start), .stage_len(stage_len),
    .in_valid(in_valid), .in_bank_index(in_bank_index), .in_bank_addr(in_bank_addr),
    .in_real(in_real), .in_imag(in_imag), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .stage_done(stage_done), .busy(busy),
    .err_conflict(err_conflict), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] nar(input logic signed [29:0] v);
`ifdef MRD_RDX2345_WB_SAT_EN
    if (v > 30'sd131071) return 18'h1ffff;
    if (v < -30'sd131072) return 18'h20000;
`endif
    return v[17:0];
  endfunction

  task automatic model_reset();
    m_state = 0; m_cnt = 0; m_len = 0; m_en = '0; m_conf = 0; m_proto = 0;
    for (int b = 0; b < 5; b++) begin m_addr[b] = '0; m_data[b] = '0; end
  endtask

  // model of one clock edge, evaluated on the inputs present just before it
  task automatic model_next();
    bit acc;
    acc = in_valid && m_state == 1 && !stage_start;
    m_en = '0;
    if (acc)
      for (int l = 0; l < 5; l++) begin
        int b = int'(in_bank_index[l]);
        if (b > 4) m_proto = 1;
        else if (m_en[b]) m_conf = 1;
        else begin
          m_en[b] = 1;
          m_addr[b] = in_bank_addr[l];
          m_data[b] = {nar(in_real[l]), nar(in_imag[l])};
        end
      end
    if (stage_start) begin
      m_state = stage_len != 0 ? 1 : 0; m_cnt = 0; m_len = int'(stage_len);
      m_conf = 0; m_proto = stage_len == 0;
    end else if (m_state == 2) begin
      m_state = 0;
      if (in_valid) m_proto = 1;
    end else if (acc) begin
      m_cnt++;
      if (m_cnt == m_len) m_state = 2;
    end else if (in_valid) m_proto = 1;
  endtask

  task automatic compare();
    chk("wr_en", 64'(wr_en), 64'(m_en));
    chk("stage_done", 64'(stage_done), 64'(m_state == 2));
    chk("busy", 64'(busy), 64'(m_state == 1));
    chk("err_conflict", 64'(err_conflict), 64'(m_conf));
    chk("err_proto", 64'(err_proto), 64'(m_proto));
    for (int b = 0; b < 5; b++) begin
      chk($sformatf("wr_addr[%0d]", b), 64'(wr_addr[b]), 64'(m_addr[b]));
      chk($sformatf("wr_data[%0d]", b), 64'(wr_data[b]), 64'(m_data[b]));
    end
  endtask

  task automatic step();
    model_next();
    @(posedge clk); #1;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 0; model_reset(); #1;
    compare();
    @(posedge clk); #1;
    rst_n = 1;
    compare();
  endtask

  task automatic start(input int len);
    stage_start = 1; stage_len = 11'(len); in_valid = 0;
    step();
    stage_start = 0;
  endtask

  task automatic set_lanes(input int idx [5]);
    for (int l = 0; l < 5; l++) begin
      in_bank_index[l] = 3'(idx[l]);
      in_bank_addr[l] = 8'(l * 10);
      in_real[l] = 30'(l + 1);
      in_imag[l] = 30'(100 + l);
    end
  endtask

  task automatic rnd_beat();
    int p [5] = '{0, 1, 2, 3, 4};
    logic signed [17:0] s;
    for (int i = 4; i > 0; i--) begin
      int j = $urandom_range(0, i);
      int t = p[i]; p[i] = p[j]; p[j] = t;
    end
    in_valid = $urandom_range(0, 3) != 0;
    for (int l = 0; l < 5; l++) begin
      int r = $urandom_range(0, 9);
      in_bank_index[l] = r == 0 ? 3'($urandom_range(5, 7)) : r < 3 ? 3'($urandom_range(0, 4)) : 3'(p[l]);
      in_bank_addr[l] = 8'($urandom);
      s = 18'($urandom);
      in_real[l] = $urandom_range(0, 1) ? 30'($urandom) : 30'(s);
      s = 18'($urandom);
      in_imag[l] = $urandom_range(0, 1) ? 30'($urandom) : 30'(s);
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    // 1: identity routing, three beats, done pulse with third write
    start(3);
    set_lanes('{0, 1, 2, 3, 4});
    in_valid = 1;
    for (int i = 0; i < 3; i++) step();
    chk("t1_done", 64'(stage_done), 64'd1);
    chk("t1_en", 64'(wr_en), 64'h1f);
    chk("t1_addr3", 64'(wr_addr[3]), 64'd30);
    in_valid = 0;
    step();
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_done_off", 64'(stage_done), 64'd0);
    // 2: permuted routing
    start(1);
    set_lanes('{4, 3, 2, 1, 0});
    in_valid = 1;
    step();
    in_valid = 0;
    chk("t2_b4_re", 64'(wr_data[4][35:18]), 64'd1);
    chk("t2_b0_re", 64'(wr_data[0][35:18]), 64'd5);
    chk("t2_errs", 64'({err_conflict, err_proto}), 64'd0);
    step();
    // 3: conflict, lane 0 wins bank 2, bank 4 idle
    start(2);
    set_lanes('{2, 2, 0, 1, 3});
    in_valid = 1;
    step();
    in_valid = 0;
    chk("t3_b2_re", 64'(wr_data[2][35:18]), 64'd1);
    chk("t3_b4_en", 64'(wr_en[4]), 64'd0);
    chk("t3_conf", 64'(err_conflict), 64'd1);
    for (int i = 0; i < 3; i++) step();
    chk("t3_conf_sticky", 64'(err_conflict), 64'd1);
    start(1);
    chk("t3_conf_clr", 64'(err_conflict), 64'd0);
    in_valid = 1; set_lanes('{0, 1, 2, 3, 4});
    step();
    in_valid = 0;
    step();
    // 4: valid in IDLE, then illegal lane index in RUN
    in_valid = 1;
    step();
    in_valid = 0;
    chk("t4_idle_en", 64'(wr_en), 64'd0);
    chk("t4_idle_proto", 64'(err_proto), 64'd1);
    start(2);
    set_lanes('{0, 1, 6, 3, 4});
    in_valid = 1;
    step();
    chk("t4_drop_en", 64'(wr_en), 64'b11011);
    chk("t4_proto", 64'(err_proto), 64'd1);
    step();
    in_valid = 0;
    step();
    // 5: narrowing boundaries
    start(1);
    set_lanes('{0, 1, 2, 3, 4});
    in_real[0] = 30'sd1048576;
    in_real[1] = -30'sd1048576;
    in_valid = 1;
    step();
    in_valid = 0;
`ifdef MRD_RDX2345_WB_SAT_EN
    chk("t5_pos", 64'(wr_data[0][35:18]), 64'd131071);
    chk("t5_neg", 64'(wr_data[1][35:18]), 64'h20000);
`else
    chk("t5_pos", 64'(wr_data[0][35:18]), 64'd0);
    chk("t5_neg", 64'(wr_data[1][35:18]), 64'd0);
`endif
    step();
    // zero-length start is rejected
    start(0);
    chk("len0_proto", 64'(err_proto), 64'd1);
    chk("len0_busy", 64'(busy), 64'd0);
    // 6: reset mid-stage, stale beats ignored, clean restart
    start(4);
    set_lanes('{0, 1, 2, 3, 4});
    in_valid = 1;
    step(); step();
    do_reset();
    chk("t6_rst_en", 64'(wr_en), 64'd0);
    step(); step();
    chk("t6_proto", 64'(err_proto), 64'd1);
    in_valid = 0;
    start(4);
    in_valid = 1;
    for (int i = 0; i < 4; i++) step();
    chk("t6_done", 64'(stage_done), 64'd1);
    in_valid = 0;
    step();
    // randomized stages, including restarts and zero lengths
    for (int s = 0; s < 40; s++) begin
      start($urandom_range(0, 12) == 0 ? 0 : $urandom_range(1, 8));
      for (int c = $urandom_range(2, 12); c > 0; c--) begin
        rnd_beat();
        if ($urandom_range(0, 30) == 0) begin stage_start = 1; stage_len = 11'($urandom_range(0, 6)); end
        step();
        stage_start = 0;
      end
      in_valid = 0;
    end
    step();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
